// File: rtl/pingpong_rd_sched.sv
// pingpong_rd_sched
// -----------------
// Read-side scheduler for a ping-pong pair of asynchronous FIFOs, living in
// the read clock domain. It drains the two FIFOs alternately in bursts of at
// most BURST words. It issues each FIFO's pop request and places the popped
// words on one registered valid/ready stream, tagged with the source FIFO.
//
// Ports
//   rclk, rrst              read clock, asynchronous active-high reset
//   ping_rempty/ping_rdata  ping FIFO read port (rdata follows the read address)
//   ping_r_req              ping FIFO pop request
//   pong_rempty/pong_rdata  pong FIFO read port
//   pong_r_req              pong FIFO pop request
//   out_data/out_src        registered output word and its source (0 ping, 1 pong)
//   out_valid/out_ready     output handshake
//   sel                     current state: 00 IDLE, 01 PING, 10 PONG
module pingpong_rd_sched #(
  parameter int DSIZE = 8,
  parameter int BURST = 4   // legal range 1..255
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             ping_rempty,
  input  logic [DSIZE-1:0] ping_rdata,
  output logic             ping_r_req,
  input  logic             pong_rempty,
  input  logic [DSIZE-1:0] pong_rdata,
  output logic             pong_r_req,
  output logic [DSIZE-1:0] out_data,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       sel
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PING = 2'b01,
    ST_PONG = 2'b10
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(BURST - 1);

  state_e           state_q,     state_d;
  logic [7:0]       cnt_q,       cnt_d;
  logic             last_src_q,  last_src_d;
  logic [DSIZE-1:0] out_data_q,  out_data_d;
  logic             out_src_q,   out_src_d;
  logic             out_valid_q, out_valid_d;

  logic can_load;
  logic ping_pop;
  logic pong_pop;

  // The output register can take a word when it is empty or being drained.
  assign can_load = !out_valid_q || out_ready;

  // Requests only come from the active state and only toward a non-empty
  // FIFO; the rrst term keeps both low for the whole reset assertion.
  assign ping_pop = !rrst && (state_q == ST_PING) && can_load && !ping_rempty;
  assign pong_pop = !rrst && (state_q == ST_PONG) && can_load && !pong_rempty;

  assign ping_r_req = ping_pop;
  assign pong_r_req = pong_pop;

  always_comb begin
    // NOTE: every variable assigned here gets a default first with blocking
    // '=', so no path leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_src_d  = last_src_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!ping_rempty && !pong_rempty) begin
          // Contention: serve the FIFO that was not served last.
          state_d = last_src_q ? ST_PING : ST_PONG;
        end else if (!ping_rempty) begin
          state_d = ST_PING;
        end else if (!pong_rempty) begin
          state_d = ST_PONG;
        end
      end

      ST_PING: begin
        if (ping_pop) begin
          // Burst-done takes priority over an empty flag seen in the same cycle.
          if (cnt_q == CNT_LAST) begin
            state_d = pong_rempty ? ST_IDLE : ST_PONG;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (ping_rempty) begin
          state_d = pong_rempty ? ST_IDLE : ST_PONG;
        end
        // Otherwise stalled on backpressure: hold state and count.
      end

      ST_PONG: begin
        if (pong_pop) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ping_rempty ? ST_IDLE : ST_PING;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (pong_rempty) begin
          state_d = ping_rempty ? ST_IDLE : ST_PING;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Any state change starts a fresh burst; entering a service state
    // records which FIFO is being served for the next contention.
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == ST_PING) last_src_d = 1'b0;
      if (state_d == ST_PONG) last_src_d = 1'b1;
    end

    // Output register: load on a pop, otherwise empty it once accepted.
    if (ping_pop) begin
      out_data_d  = ping_rdata;
      out_src_d   = 1'b0;
      out_valid_d = 1'b1;
    end else if (pong_pop) begin
      out_data_d  = pong_rdata;
      out_src_d   = 1'b1;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state is updated only here with non-blocking '<=' so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_src_q  <= 1'b1;   // first contention after reset goes to ping
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_src_q  <= last_src_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;
  assign sel       = state_q;

endmodule

// File: tb/tb_pingpong_rd_sched.sv
// Directed bench for pingpong_rd_sched. Two small FIFO read-port models
// (combinational rdata, registered rempty) feed the scheduler; a monitor
// records every accepted output word for comparison against hand-computed
// expectations.
module tb_pingpong_rd_sched;

  localparam int DSIZE = 8;
  localparam int BURST = 4;

  logic             rclk = 1'b0;
  logic             rrst;
  logic             ping_rempty, pong_rempty;
  logic [DSIZE-1:0] ping_rdata,  pong_rdata;
  logic             ping_r_req,  pong_r_req;
  logic [DSIZE-1:0] out_data;
  logic             out_src;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       sel;

  pingpong_rd_sched #(.DSIZE(DSIZE), .BURST(BURST)) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .ping_rempty (ping_rempty),
    .ping_rdata  (ping_rdata),
    .ping_r_req  (ping_r_req),
    .pong_rempty (pong_rempty),
    .pong_rdata  (pong_rdata),
    .pong_r_req  (pong_r_req),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sel         (sel)
  );

  always #5 rclk = ~rclk;

  // ---------------- FIFO read-port models ----------------
  logic [7:0] ping_mem [0:63];
  logic [7:0] pong_mem [0:63];
  int ping_wcnt, pong_wcnt;
  int ping_rptr, pong_rptr;

  assign ping_rdata = ping_mem[ping_rptr[5:0]];
  assign pong_rdata = pong_mem[pong_rptr[5:0]];

  always @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      ping_rptr   <= 0;
      pong_rptr   <= 0;
      ping_rempty <= 1'b1;
      pong_rempty <= 1'b1;
    end else begin
      ping_rptr   <= ping_rptr + (ping_r_req ? 1 : 0);
      pong_rptr   <= pong_rptr + (pong_r_req ? 1 : 0);
      ping_rempty <= ((ping_rptr + (ping_r_req ? 1 : 0)) == ping_wcnt);
      pong_rempty <= ((pong_rptr + (pong_r_req ? 1 : 0)) == pong_wcnt);
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] got_data [0:255];
  logic       got_src  [0:255];
  int         got_cyc  [0:255];
  int got_n      = 0;
  int cyc        = 0;
  int violations = 0;
  int ping_req_n = 0;

  always @(posedge rclk) cyc <= cyc + 1;

  always @(negedge rclk) begin
    if (!rrst) begin
      if (out_valid && out_ready) begin
        got_data[got_n] = out_data;
        got_src[got_n]  = out_src;
        got_cyc[got_n]  = cyc;
        got_n           = got_n + 1;
      end
      if ((ping_r_req || pong_r_req) && out_valid && !out_ready) violations = violations + 1;
      if (ping_r_req && pong_r_req) violations = violations + 1;
      if (ping_r_req && ping_rempty) violations = violations + 1;
      if (pong_r_req && pong_rempty) violations = violations + 1;
      if (ping_r_req) ping_req_n = ping_req_n + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_ping(input logic [7:0] d);
    ping_mem[ping_wcnt] = d;
    ping_wcnt = ping_wcnt + 1;
  endtask

  task automatic push_pong(input logic [7:0] d);
    pong_mem[pong_wcnt] = d;
    pong_wcnt = pong_wcnt + 1;
  endtask

  task automatic wait_words(input string tag, input int target);
    for (int i = 0; i < 200; i++) begin
      if (got_n >= target) break;
      tick();
    end
    check(tag, got_n, target);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (sel == 2'b00) break;
      tick();
    end
    check(tag, {30'd0, sel}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0]  exp_alt [0:15] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
                                  8'h14, 8'h15, 8'h16, 8'h17, 8'h24, 8'h25, 8'h26, 8'h27};
  logic [7:0]  exp_drain [0:7] = '{8'h30, 8'h31, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
  logic [15:0] srcs;
  int base;
  int ping_req_before;

  initial begin
    rrst      = 1'b1;
    out_ready = 1'b1;
    ping_wcnt = 0;
    pong_wcnt = 0;

    // Reset state
    #2;
    check("rst_sel",       {30'd0, sel}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data}, 32'd0);
    check("rst_out_src",   {31'd0, out_src}, 32'd0);
    check("rst_ping_req",  {31'd0, ping_r_req}, 32'd0);
    check("rst_pong_req",  {31'd0, pong_r_req}, 32'd0);
    tick();
    tick();
    rrst = 1'b0;
    tick();

    // Alternation: both loaded at once, first contention goes to ping
    base = got_n;
    for (int i = 0; i < 8; i++) begin
      push_ping(8'h10 + 8'(i));
      push_pong(8'h20 + 8'(i));
    end
    tick();
    tick();
    check("alt_first_sel", {30'd0, sel}, 32'd1);
    wait_words("alt_count", base + 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("alt_data%0d", i), {24'd0, got_data[base + i]}, {24'd0, exp_alt[i]});
      srcs[15 - i] = got_src[base + i];
    end
    check("alt_src", {16'd0, srcs}, {16'd0, 16'b0000111100001111});
    check("alt_no_gap", got_cyc[base + 15] - got_cyc[base], 32'd15);
    wait_idle("alt_idle");

    // Single source: only pong has data
    base = got_n;
    ping_req_before = ping_req_n;
    push_pong(8'h20);
    push_pong(8'h21);
    tick();
    tick();
    check("single_sel",      {30'd0, sel}, 32'd2);
    check("single_pop_lat",  {31'd0, pong_r_req}, 32'd1);
    wait_words("single_count", base + 2);
    check("single_w0", {23'd0, got_src[base], got_data[base]}, {23'd0, 1'b1, 8'h20});
    check("single_w1", {23'd0, got_src[base + 1], got_data[base + 1]}, {23'd0, 1'b1, 8'h21});
    wait_idle("single_idle");
    check("single_no_ping_req", ping_req_n, ping_req_before);

    // Backpressure after the second ping word
    base = got_n;
    for (int i = 0; i < 4; i++) push_ping(8'h10 + 8'(i));
    tick();
    tick();
    tick();
    tick();
    check("bp_second_word", {24'd0, out_data}, 32'h11);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      check($sformatf("bp_hold_data%0d", i),  {24'd0, out_data}, 32'h11);
      check($sformatf("bp_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_no_req%0d", i),     {31'd0, ping_r_req}, 32'd0);
      @(posedge rclk);
      #1;
    end
    out_ready = 1'b1;
    wait_words("bp_count", base + 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_data%0d", i), {24'd0, got_data[base + i]}, 32'h10 + i);
    wait_idle("bp_idle");
    tick();
    check("bp_no_dup", got_n, base + 4);

    // Early drain: ping 2 words, pong 6 words
    base = got_n;
    push_ping(8'h30);
    push_ping(8'h31);
    tick();
    for (int i = 0; i < 6; i++) push_pong(8'h40 + 8'(i));
    tick();
    check("drain_sel_ping", {30'd0, sel}, 32'd1);
    tick();
    tick();
    tick();
    check("drain_sel_pong", {30'd0, sel}, 32'd2);
    tick();
    tick();
    tick();
    tick();
    check("drain_burst_done_idle", {30'd0, sel}, 32'd0);
    wait_words("drain_count", base + 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("drain_w%0d", i), {23'd0, got_src[base + i], got_data[base + i]},
            {23'd0, (i >= 2), exp_drain[i]});
    wait_idle("drain_idle");

    // Fairness: ping served last, then simultaneous arrival goes to pong
    base = got_n;
    push_ping(8'h50);
    wait_words("fair_pre_count", base + 1);
    wait_idle("fair_pre_idle");
    push_ping(8'h51);
    push_pong(8'h60);
    tick();
    tick();
    check("fair_sel_pong", {30'd0, sel}, 32'd2);
    wait_words("fair_count", base + 3);
    check("fair_w1", {23'd0, got_src[base + 1], got_data[base + 1]}, {23'd0, 1'b1, 8'h60});
    check("fair_w2", {23'd0, got_src[base + 2], got_data[base + 2]}, {23'd0, 1'b0, 8'h51});
    wait_idle("fair_idle");

    // Reset mid-burst
    for (int i = 0; i < 8; i++) push_ping(8'h70 + 8'(i));
    tick();
    tick();
    tick();
    tick();
    check("midrst_pre_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rrst = 1'b1;
    ping_wcnt = 0;
    pong_wcnt = 0;
    #1;
    check("midrst_valid",    {31'd0, out_valid}, 32'd0);
    check("midrst_ping_req", {31'd0, ping_r_req}, 32'd0);
    check("midrst_pong_req", {31'd0, pong_r_req}, 32'd0);
    check("midrst_sel",      {30'd0, sel}, 32'd0);
    tick();
    rrst = 1'b0;
    tick();
    base = got_n;
    push_ping(8'h80);
    push_pong(8'h90);
    tick();
    tick();
    check("postrst_sel_ping", {30'd0, sel}, 32'd1);
    wait_words("postrst_count", base + 2);
    check("postrst_w0", {23'd0, got_src[base], got_data[base]}, {23'd0, 1'b0, 8'h80});
    check("postrst_w1", {23'd0, got_src[base + 1], got_data[base + 1]}, {23'd0, 1'b1, 8'h90});
    wait_idle("postrst_idle");

    check("req_rule_violations", violations, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
